// File: rtl/pipe_ctl_if.sv
// rtl/pipe_ctl_if.sv - Signal bundle between the Y86 pipeline and its controller
// Purpose: groups the hazard-detection inputs, the data-memory handshake and
//          the stall/bubble/status outputs of pipe_ctl.
// Modports:
//   slave  - controller side: reads pipeline state, drives controls and status
//   master - pipeline side: drives pipeline state, reads controls and status
// Signals:
//   start_i, D/E/M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i, e_Cnd_i,
//   m_stat_i, W_stat_i, M_mem_i, dmem_ready_i                 pipeline -> ctl
//   F/D/E/M/W_stall_o, D/E/M/W_bubble_o, m_buserr_o,
//   halted_o, stat_o, cyc_cnt_o, stall_cnt_o                  ctl -> pipeline
interface pipe_ctl_if #(
   parameter int CNT_W = 32
);
   logic             start_i;
   logic [3:0]       D_icode_i;
   logic [3:0]       E_icode_i;
   logic [3:0]       M_icode_i;
   logic [3:0]       E_dstM_i;
   logic [3:0]       d_srcA_i;
   logic [3:0]       d_srcB_i;
   logic             e_Cnd_i;
   logic [3:0]       m_stat_i;
   logic [3:0]       W_stat_i;
   logic             M_mem_i;
   logic             dmem_ready_i;

   logic             F_stall_o;
   logic             D_stall_o;
   logic             E_stall_o;
   logic             M_stall_o;
   logic             W_stall_o;
   logic             D_bubble_o;
   logic             E_bubble_o;
   logic             M_bubble_o;
   logic             W_bubble_o;
   logic             m_buserr_o;
   logic             halted_o;
   logic [3:0]       stat_o;
   logic [CNT_W-1:0] cyc_cnt_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport slave (
      input  start_i, D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
             e_Cnd_i, m_stat_i, W_stat_i, M_mem_i, dmem_ready_i,
      output F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
             D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
             m_buserr_o, halted_o, stat_o, cyc_cnt_o, stall_cnt_o
   );

   modport master (
      output start_i, D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
             e_Cnd_i, m_stat_i, W_stat_i, M_mem_i, dmem_ready_i,
      input  F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
             D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
             m_buserr_o, halted_o, stat_o, cyc_cnt_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - Y86 pipeline stall/bubble controller with memory timeout
// Purpose: drives stall/bubble controls of the F/D/E/M/W pipeline registers,
//          resolving load/use, ret, mispredict and exception hazards; freezes
//          the pipe on a slow data memory and forces a bus error on a hung
//          access; halts on a non-AOK writeback status; counts active and
//          fetch-stalled cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - pipe_ctl_if.slave: pipeline state in, controls/status out
module pipe_ctl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic      clk,
   input  logic      rst,
   pipe_ctl_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_MWAIT  = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   localparam logic [3:0] IMRMOVL = 4'h5;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPOPL   = 4'hB;

   localparam logic [3:0] SAOK = 4'd1;
   localparam logic [3:0] SADR = 4'd2;
   localparam logic [3:0] SINS = 4'd3;
   localparam logic [3:0] SHLT = 4'd4;

   // The wait counter holds the number of not-ready cycles already absorbed;
   // the access is abandoned on the cycle that would be the MEM_TIMEOUT-th.
   localparam int               WCNT_W    = $clog2(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [3:0]        stat_q, stat_d;

   logic lu, rt, mp, ex;
   logic active, halt, mem_wait, timeout;
   logic f_stall, d_stall, e_stall, m_stall, w_stall;
   logic d_bub, e_bub, m_bub, w_bub;
   logic buserr;

   function automatic logic is_exc(input logic [3:0] s);
      return (s == SADR) || (s == SINS) || (s == SHLT);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      lu = ((bus.E_icode_i == IMRMOVL) || (bus.E_icode_i == IPOPL)) &&
           ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
      rt = (bus.D_icode_i == IRET) || (bus.E_icode_i == IRET) || (bus.M_icode_i == IRET);
      mp = (bus.E_icode_i == IJXX) && !bus.e_Cnd_i;
      ex = is_exc(bus.m_stat_i) || is_exc(bus.W_stat_i);
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      stat_d      = stat_q;
      cyc_cnt_d   = cyc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      f_stall     = 1'b0;
      d_stall     = 1'b0;
      e_stall     = 1'b0;
      m_stall     = 1'b0;
      w_stall     = 1'b0;
      d_bub       = 1'b0;
      e_bub       = 1'b0;
      m_bub       = 1'b0;
      w_bub       = 1'b0;
      buserr      = 1'b0;

      active   = (state_q == S_RUN) || (state_q == S_MWAIT);
      // Halt outranks a pending memory wait: the faulting instruction must retire.
      halt     = active && (bus.W_stat_i != SAOK);
      mem_wait = active && !halt && bus.M_mem_i && !bus.dmem_ready_i;
      timeout  = mem_wait && (wait_cnt_q == WCNT_LAST);

      case (state_q)
         S_IDLE: begin
            f_stall = 1'b1;
            d_bub   = 1'b1;
            e_bub   = 1'b1;
            m_bub   = 1'b1;
            if (bus.start_i) begin
               state_d = S_RUN;
            end
         end
         S_HALTED: begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_stall = 1'b1;
            m_stall = 1'b1;
            w_stall = 1'b1;
         end
         default: begin
            if (mem_wait && !timeout) begin
               // Freeze everything up to M; W gets a bubble so nothing retires twice.
               f_stall    = 1'b1;
               d_stall    = 1'b1;
               e_stall    = 1'b1;
               m_stall    = 1'b1;
               w_bub      = 1'b1;
               wait_cnt_d = wait_cnt_q + 1'b1;
               state_d    = S_MWAIT;
            end else begin
               // On timeout the instruction advances normally; M tags it SADR.
               f_stall    = lu | rt;
               d_stall    = lu;
               d_bub      = mp | (!lu & rt);
               e_bub      = mp | lu;
               m_bub      = ex;
               w_stall    = halt;
               buserr     = timeout;
               wait_cnt_d = '0;
               state_d    = S_RUN;
               if (halt) begin
                  // Ordinary hazard controls still apply; fetch is held as well.
                  f_stall = 1'b1;
                  state_d = S_HALTED;
                  stat_d  = bus.W_stat_i;
               end
            end
            cyc_cnt_d = sat_inc(cyc_cnt_q);
            if (f_stall) begin
               stall_cnt_d = sat_inc(stall_cnt_q);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= '0;
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
         stat_q      <= SAOK;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         stat_q      <= stat_d;
      end
   end

   // A register never sees stall and bubble together; stall wins.
   assign bus.F_stall_o   = f_stall;
   assign bus.D_stall_o   = d_stall;
   assign bus.E_stall_o   = e_stall;
   assign bus.M_stall_o   = m_stall;
   assign bus.W_stall_o   = w_stall;
   assign bus.D_bubble_o  = d_bub & !d_stall;
   assign bus.E_bubble_o  = e_bub & !e_stall;
   assign bus.M_bubble_o  = m_bub & !m_stall;
   assign bus.W_bubble_o  = w_bub & !w_stall;
   assign bus.m_buserr_o  = buserr;
   assign bus.halted_o    = (state_q == S_HALTED);
   assign bus.stat_o      = stat_q;
   assign bus.cyc_cnt_o   = cyc_cnt_q;
   assign bus.stall_cnt_o = stall_cnt_q;
endmodule
